modexp_decrypt: RTL and testbench
=================================

# modexp_decrypt

Sequential modular-exponentiation engine that computes m = c^d mod n, the decryption side of the team's ERYTH modular-arithmetic crypto datapath. A start/busy/done handshake launches one operation over a fixed number of cycles; operands are captured at start. The engine uses right-to-left square-and-multiply with constant latency, so timing does not depend on the exponent value. It sits beside the existing arithmetic units and its result can feed the output mux as an additional selectable result.

## Interface
- WIDTH, default 8: operand and result width in bits; also the iteration count.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request an operation; sampled only in IDLE.
- c  input  WIDTH  ciphertext or base.
- d  input  WIDTH  private exponent.
- n  input  WIDTH  modulus.
- busy  output  1  high in LOAD, ITER and DONE.
- done  output  1  one-cycle pulse; m and err are valid from this cycle.
- m  output  WIDTH  result, c^d mod n.
- err  output  1  set with done when n == 0.

## Operation
- Registers:
  - cap_d, cap_n: WIDTH bits.
  - base, acc: WIDTH bits.
  - e: WIDTH bits, exponent shift register.
  - cnt: iteration counter, clog2(WIDTH+1) bits.
- State machine states are IDLE, LOAD, ITER and DONE.
- IDLE:
  - When start = 1: capture c into base, d into cap_d, n into cap_n, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If cap_n == 0: m <= 0, err <= 1, go to DONE. ITER is skipped.
  - Otherwise:
    - base <= base mod cap_n
    - acc <= 1 mod cap_n (0 when n = 1)
    - e <= cap_d
    - cnt <= 0
    - err <= 0
    - go to ITER.
- ITER, one exponent bit per cycle:
  - If e[0] = 1: acc <= (acc * base) mod cap_n.
  - Always: base <= (base * base) mod cap_n; e <= e >> 1; cnt <= cnt + 1.
  - Both products are full 2*WIDTH-bit values, reduced mod cap_n in the same cycle.
  - Both updates use the pre-edge base.
  - When cnt == WIDTH-1, load m with the updated acc value and go to DONE.
- No early exit on e == 0. Every operation runs exactly WIDTH ITER cycles.
- DONE:
  - done = 1 for this single cycle.
  - Go to IDLE unconditionally. A start held high in DONE is ignored.
- m and err hold their values until the next operation's LOAD/DONE writes them.
- Input changes on c, d and n while busy = 1 have no effect.
- Reset, at any time including mid-operation:
  - state returns to IDLE and the in-flight operation is discarded.
  - busy = 0, done = 0, m = 0, err = 0.
  - All internal registers clear.
- Arithmetic rules:
  - c >= n is legal; it is reduced in LOAD.
  - d = 0 yields 1 mod n.
  - n = 1 yields m = 0 with err = 0.

## Timing
- Let start be sampled high at edge T in IDLE.
  - Cycle T+1 is LOAD, busy = 1.
  - Cycles T+2 through T+WIDTH+1 are ITER.
  - Cycle T+WIDTH+2 is DONE: done = 1 and m is valid.
- Latency from start to done is WIDTH+2 cycles: 10 for WIDTH = 8.
- The n == 0 path: done at T+2.
- busy is high during cycles T+1 through T+WIDTH+2, and low in IDLE.
- The earliest next start is sampled in the cycle after DONE.
  - With start held high continuously, operations begin every WIDTH+3 cycles.
- done is never high for two consecutive cycles.
- Reset has priority over start in the same cycle.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- RSA round-trip. Stimulus: c=31, d=7, n=33. Required: done exactly 10 cycles after start; m=4, err=0.
- General case. Stimulus: c=4, d=13, n=25. Required: m=14. Then c=200, d=1, n=7. Required: m=4, which exercises base reduction.
- Edge operands:
  - d=0, n=7 gives m=1.
  - n=1, c=9, d=5 gives m=0, err=0.
  - n=0 gives done 2 cycles after start, m=0, err=1.
- Handshake. Hold start high for 30 cycles. Required: done pulses at cycles 10, 21 and 32 relative to the first sample; start pulses while busy are ignored; c, d and n toggled mid-operation do not change m.
- Reset mid-operation. Assert rst at the 5th ITER cycle. Required: next cycle busy=0, done=0, m=0, err=0. A following start with c=31, d=7, n=33 gives m=4.
- Randomized check. 500 random (c, d, n≠0) tuples compared against a reference model of c^d mod n. Required: every m matches and every latency is exactly 10 cycles.

Source files
------------

// File: rtl/modexp_decrypt_if.sv
// Handshake and operand bus for the modular-exponentiation engine.
// Signal prefixes are from the engine's point of view: i_ feeds the engine, o_ comes back.
interface modexp_decrypt_if #(
  parameter int WIDTH = 8
) ();
  logic             i_start;
  logic [WIDTH-1:0] i_c;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] i_n;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_m;
  logic             o_err;

  // Requester side: launches operations and reads results.
  modport master (
    output i_start, i_c, i_d, i_n,
    input  o_busy, o_done, o_m, o_err
  );

  // Engine side.
  modport slave (
    input  i_start, i_c, i_d, i_n,
    output o_busy, o_done, o_m, o_err
  );
endinterface

// File: rtl/modexp_decrypt.sv
// Constant-latency modular exponentiation m = c^d mod n, right-to-left
// square-and-multiply, one exponent bit per cycle for exactly WIDTH cycles.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// LOAD  | reduce base mod n, seed acc, or flag err when n == 0
// ITER  | one exponent bit per cycle, WIDTH cycles, no early exit
// DONE  | one-cycle done pulse; m/err valid; start ignored
module modexp_decrypt #(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  modexp_decrypt_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cap_d;
  logic [WIDTH-1:0] r_cap_n;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_e;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m;
  logic             r_err;

  logic [2*WIDTH-1:0] w_n_ext;
  logic [2*WIDTH-1:0] w_base_sq;
  logic [2*WIDTH-1:0] w_acc_prod;
  logic [WIDTH-1:0]   w_base_sq_mod;
  logic [WIDTH-1:0]   w_acc_prod_mod;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_base_red;
  logic [WIDTH-1:0]   w_acc_init;
  logic               w_n_zero;
  logic               w_last;

  // Full-width products reduced in the same cycle; both use the pre-edge base.
  assign w_n_ext        = {{WIDTH{1'b0}}, r_cap_n};
  assign w_base_sq      = {{WIDTH{1'b0}}, r_base} * {{WIDTH{1'b0}}, r_base};
  assign w_acc_prod     = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_base};
  assign w_base_sq_mod  = WIDTH'(w_base_sq % w_n_ext);
  assign w_acc_prod_mod = WIDTH'(w_acc_prod % w_n_ext);
  assign w_acc_nxt      = r_e[0] ? w_acc_prod_mod : r_acc;
  assign w_base_red     = r_base % r_cap_n;
  assign w_acc_init     = (r_cap_n == WIDTH'(1)) ? '0 : WIDTH'(1);
  assign w_n_zero       = (r_cap_n == '0);
  assign w_last         = (r_cnt == CW'(WIDTH - 1));

  // State register with reset priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.i_start) w_state_nxt = LOAD;
      LOAD: w_state_nxt = w_n_zero ? DONE : ITER;
      ITER: if (w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    bus.o_busy = 1'b0;
    bus.o_done = 1'b0;
    bus.o_busy = (r_state != IDLE);
    bus.o_done = (r_state == DONE);
  end

  assign bus.o_m   = r_m;
  assign bus.o_err = r_err;

  // Datapath: operand capture, reduction, and one square-and-multiply step per ITER cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_d <= '0;
      r_cap_n <= '0;
      r_base  <= '0;
      r_acc   <= '0;
      r_e     <= '0;
      r_cnt   <= '0;
      r_m     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_base  <= bus.i_c;
            r_cap_d <= bus.i_d;
            r_cap_n <= bus.i_n;
          end
        end
        LOAD: begin
          if (w_n_zero) begin
            r_m   <= '0;
            r_err <= 1'b1;
          end else begin
            r_base <= w_base_red;
            r_acc  <= w_acc_init;
            r_e    <= r_cap_d;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        ITER: begin
          r_acc  <= w_acc_nxt;
          r_base <= w_base_sq_mod;
          r_e    <= r_e >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_m <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_decrypt.sv
// Self-checking bench for modexp_decrypt: directed table, handshake, reset and random runs.
module tb_modexp_decrypt;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modexp_decrypt_if #(.WIDTH(W)) u_if ();
  modexp_decrypt #(.WIDTH(W)) u_dut (.i_clk(clk), .i_rst(rst), .bus(u_if));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] m;
    logic         err;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain repeated multiplication, independent of any bit-serial scheme.
  function automatic int ref_modexp(input int c, input int d, input int n);
    longint r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int i = 0; i < d; i++) r = (r * c) % n;
    return int'(r);
  endfunction

  // Launch one operation from IDLE; lat counts cycles from the start sample to done.
  // Operand inputs are scrambled while busy to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n,
                        output logic [W-1:0] m, output logic err, output int lat);
    @(negedge clk);
    u_if.i_start = 1'b1;
    u_if.i_c = c;
    u_if.i_d = d;
    u_if.i_n = n;
    @(posedge clk); #1;
    u_if.i_start = 1'b0;
    check("load_busy", {31'd0, u_if.o_busy}, 32'd1);
    lat = 1;
    while (u_if.o_done !== 1'b1 && lat < 40) begin
      u_if.i_c = W'($urandom);
      u_if.i_d = W'($urandom);
      u_if.i_n = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    m   = u_if.o_m;
    err = u_if.o_err;
    @(posedge clk); #1;
    check("after_done_idle", {30'd0, u_if.o_done, u_if.o_busy}, 32'd0);
  endtask

  vec_t         vecs[6];
  logic [W-1:0] m_got;
  logic         err_got;
  int           lat_got;
  int           done_at[$];
  int           exp_done[3] = '{10, 21, 32};

  initial begin
    vecs[0] = '{c: 8'd31,  d: 8'd7,  n: 8'd33, m: 8'd4,  err: 1'b0, lat: 10};
    vecs[1] = '{c: 8'd4,   d: 8'd13, n: 8'd25, m: 8'd14, err: 1'b0, lat: 10};
    vecs[2] = '{c: 8'd200, d: 8'd1,  n: 8'd7,  m: 8'd4,  err: 1'b0, lat: 10};
    vecs[3] = '{c: 8'd9,   d: 8'd0,  n: 8'd7,  m: 8'd1,  err: 1'b0, lat: 10};
    vecs[4] = '{c: 8'd9,   d: 8'd5,  n: 8'd1,  m: 8'd0,  err: 1'b0, lat: 10};
    vecs[5] = '{c: 8'd5,   d: 8'd3,  n: 8'd0,  m: 8'd0,  err: 1'b1, lat: 2};

    rst = 1'b1;
    u_if.i_start = 1'b0;
    u_if.i_c = '0;
    u_if.i_d = '0;
    u_if.i_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, u_if.o_busy}, 32'd0);
    check("rst_done", {31'd0, u_if.o_done}, 32'd0);
    check("rst_m",    {24'd0, u_if.o_m},    32'd0);
    check("rst_err",  {31'd0, u_if.o_err},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, including n=0 error path and n=1 / d=0 edges.
    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].d, vecs[i].n, m_got, err_got, lat_got);
      check($sformatf("vec%0d_m", i),   {24'd0, m_got},      {24'd0, vecs[i].m});
      check($sformatf("vec%0d_err", i), {31'd0, err_got},    {31'd0, vecs[i].err});
      check($sformatf("vec%0d_lat", i), lat_got,             vecs[i].lat);
    end

    // Start held high for 30 cycles; operands scrambled whenever busy.
    @(negedge clk);
    u_if.i_start = 1'b1;
    u_if.i_c = 8'd31;
    u_if.i_d = 8'd7;
    u_if.i_n = 8'd33;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (u_if.o_done === 1'b1) begin
        done_at.push_back(k);
        check($sformatf("hs_m_at%0d", k),   {24'd0, u_if.o_m},   32'd4);
        check($sformatf("hs_err_at%0d", k), {31'd0, u_if.o_err}, 32'd0);
      end
      if (k == 30) u_if.i_start = 1'b0;
      if (u_if.o_busy === 1'b1) begin
        u_if.i_c = W'($urandom);
        u_if.i_d = W'($urandom);
        u_if.i_n = W'($urandom);
      end else begin
        u_if.i_c = 8'd31;
        u_if.i_d = 8'd7;
        u_if.i_n = 8'd33;
      end
    end
    check("hs_done_count", done_at.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < done_at.size()) check($sformatf("hs_done%0d_cycle", i), done_at[i], exp_done[i]);

    // Reset during the 5th ITER cycle discards the operation and clears outputs.
    @(negedge clk);
    u_if.i_start = 1'b1;
    u_if.i_c = 8'd31;
    u_if.i_d = 8'd7;
    u_if.i_n = 8'd33;
    @(posedge clk); #1;
    u_if.i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, u_if.o_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, u_if.o_busy}, 32'd0);
    check("midrst_done", {31'd0, u_if.o_done}, 32'd0);
    check("midrst_m",    {24'd0, u_if.o_m},    32'd0);
    check("midrst_err",  {31'd0, u_if.o_err},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd31, 8'd7, 8'd33, m_got, err_got, lat_got);
    check("post_rst_m",   {24'd0, m_got},   32'd4);
    check("post_rst_err", {31'd0, err_got}, 32'd0);
    check("post_rst_lat", lat_got,          32'd10);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] rc, rd, rn;
      rc = W'($urandom_range(0, 255));
      rd = W'($urandom_range(0, 255));
      rn = W'($urandom_range(1, 255));
      run_op(rc, rd, rn, m_got, err_got, lat_got);
      check($sformatf("rnd%0d_m c=%0d d=%0d n=%0d", i, rc, rd, rn), {24'd0, m_got},
            ref_modexp(int'(rc), int'(rd), int'(rn)));
      check($sformatf("rnd%0d_err", i), {31'd0, err_got}, 32'd0);
      check($sformatf("rnd%0d_lat", i), lat_got,          32'd10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
